// File: rtl/rv32c_realign_buffer.sv
// RV32C fetch realignment buffer: word-aligned fetches into a circular halfword
// buffer, emitting one 16-bit or 32-bit (possibly word-straddling) instruction per handshake.
module rv32c_realign_buffer #(
    parameter int unsigned BUF_HW   = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0200
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        rv32c_ena,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_is_c
);

    localparam int unsigned PW = $clog2(BUF_HW);
    localparam int unsigned CW = PW + 1;

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    logic [15:0] r_buf [BUF_HW];
    ptr_t        r_rd_ptr;
    ptr_t        r_wr_ptr;
    cnt_t        r_count;
    logic [31:0] r_head_pc;
    logic [31:0] r_fetch_addr;
    logic [31:0] r_req_addr;
    logic        r_pending;
    logic        r_squash;
    logic        r_drop_lo;

    ptr_t        w_rd_nxt;
    ptr_t        w_wr_nxt;
    logic [15:0] w_h0;
    logic [15:0] w_h1;
    logic        w_is_c;
    logic        w_head_ok;
    cnt_t        w_free;
    logic        w_issue;
    logic        w_req;
    logic        w_accept;
    logic [1:0]  w_push_n;
    logic [1:0]  w_pop_n;

    always_comb begin
        w_rd_nxt  = r_rd_ptr + ptr_t'(1);
        w_wr_nxt  = r_wr_ptr + ptr_t'(1);
        w_h0      = r_buf[r_rd_ptr];
        w_h1      = r_buf[w_rd_nxt];
        w_is_c    = rv32c_ena && (w_h0[1:0] != 2'b11);
        w_head_ok = w_is_c ? (r_count >= cnt_t'(1)) : (r_count >= cnt_t'(2));
        w_free    = cnt_t'(BUF_HW) - r_count;
        // A new request is never launched in a flush cycle, so the only
        // request that can straddle a redirect is one already pending.
        w_issue   = !r_pending && !flush && (w_free >= cnt_t'(2));
        w_req     = r_pending || w_issue;
        w_accept  = imem_valid && w_req;
        w_push_n  = 2'd0;
        if (w_accept && !flush && !r_squash) begin
            w_push_n = r_drop_lo ? 2'd1 : 2'd2;
        end
        w_pop_n = 2'd0;
        if (w_head_ok && inst_ready && !flush) begin
            w_pop_n = w_is_c ? 2'd1 : 2'd2;
        end
    end

    assign imem_req   = nrst && w_req;
    assign imem_addr  = r_pending ? r_req_addr : r_fetch_addr;
    assign inst_valid = nrst && !flush && w_head_ok;
    assign inst_is_c  = nrst && w_is_c;
    assign inst       = !nrst ? '0 : (w_is_c ? {16'h0000, w_h0} : {w_h1, w_h0});
    assign inst_pc    = r_head_pc;

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_count      <= '0;
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_pending    <= 1'b0;
            r_squash     <= 1'b0;
            r_drop_lo    <= 1'b0;
            r_head_pc    <= RESET_PC;
            r_fetch_addr <= RESET_PC;
            r_req_addr   <= RESET_PC;
        end else if (flush) begin
            r_count      <= '0;
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_head_pc    <= flush_pc & ~32'd1;
            r_fetch_addr <= {flush_pc[31:2], 2'b00};
            r_drop_lo    <= flush_pc[1] && rv32c_ena;
            // An outstanding request still completes at its old address; its data is discarded.
            r_pending    <= r_pending && !imem_valid;
            r_squash     <= r_pending && !imem_valid;
        end else begin
            r_count   <= r_count + cnt_t'(w_push_n) - cnt_t'(w_pop_n);
            r_rd_ptr  <= r_rd_ptr + ptr_t'(w_pop_n);
            r_wr_ptr  <= r_wr_ptr + ptr_t'(w_push_n);
            r_head_pc <= r_head_pc + {29'd0, w_pop_n, 1'b0};
            if (w_accept) begin
                r_pending <= 1'b0;
                if (r_squash) begin
                    r_squash <= 1'b0;
                end else begin
                    r_fetch_addr <= r_fetch_addr + 32'd4;
                    r_drop_lo    <= 1'b0;
                end
            end else if (w_issue) begin
                r_pending  <= 1'b1;
                r_req_addr <= r_fetch_addr;
            end
            if (w_push_n == 2'd2) begin
                r_buf[r_wr_ptr] <= imem_rdata[15:0];
                r_buf[w_wr_nxt] <= imem_rdata[31:16];
            end else if (w_push_n == 2'd1) begin
                r_buf[r_wr_ptr] <= imem_rdata[31:16];
            end
        end
    end

endmodule
